// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared constants and types for the demux dispatcher.
//   NUM_CH / SEL_W : channel count and select width
//   MODE_RR/DIR    : values of the mode input
//   state_e        : buffer FSM encoding (EMPTY / FULL)
//   ptr_after()    : round-robin pointer advance (wraps 3 -> 0)
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_DIR = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic logic [SEL_W-1:0] ptr_after(input logic [SEL_W-1:0] sel);
        return sel + SEL_W'(1);
    endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Producer/consumer bus of the demux dispatcher.
//   in_data/in_dest/in_valid/in_ready : valid/ready input stream
//   y0..y3 / out_valid / out_ready    : four output channels with per-channel handshake
// master: producer+consumer side (drives inputs, sink readies); slave: the dispatcher.
interface demux_dispatch_ctrl_if
    import demux_pkg::*;
#(
    parameter int unsigned N = 4
);
    logic [N-1:0]      in_data;
    logic [SEL_W-1:0]  in_dest;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      y0;
    logic [N-1:0]      y1;
    logic [N-1:0]      y2;
    logic [N-1:0]      y3;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;

    modport master (
        output in_data, in_dest, in_valid, out_ready,
        input  in_ready, y0, y1, y2, y3, out_valid
    );

    modport slave (
        input  in_data, in_dest, in_valid, out_ready,
        output in_ready, y0, y1, y2, y3, out_valid
    );

endinterface

// File: rtl/demux_dispatch_ctrl_rr_pick4.sv
// Combinational rotate-priority picker.
//   mask : eligible channels
//   ptr  : channel searched first; search continues ptr+1, ptr+2, ... mod 4
//   sel  : first eligible channel found (ptr when none)
//   any  : at least one channel eligible
module rr_pick4
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  sel,
    output logic              any
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible channel wins.
    always_comb begin
        sel = ptr;
        any = 1'b0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (mask[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Round-robin / directed dispatcher: one-entry buffer feeding a registered 1-to-4 demux.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : 1 = accept new words (a held word drains regardless)
//   mode       : MODE_RR = round-robin, MODE_DIR = directed by bus.in_dest
//   chan_mask  : per-channel eligibility for new words
//   bus        : input stream and four output channels (slave side)
//   busy       : buffer holds a word
//   xfer_cnt   : completed output transfers, wraps
module demux_dispatch_ctrl
    import demux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [NUM_CH-1:0]   chan_mask,
    demux_dispatch_ctrl_if.slave bus,
    output logic                busy,
    output logic [CNT_W-1:0]    xfer_cnt
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              buf_valid;
    logic              drain;
    logic              eligible;
    logic              in_ready;
    logic              accept;
    logic              rr_any;
    logic [SEL_W-1:0]  rr_sel;
    logic [SEL_W-1:0]  target;
    logic [NUM_CH-1:0] out_valid;

    rr_pick4 u_rr_pick4 (
        .mask (chan_mask),
        .ptr  (rr_ptr_q),
        .sel  (rr_sel),
        .any  (rr_any)
    );

    // Handshake decode. Readiness looks only at the held word's own channel, so a
    // word arriving in the same cycle the old one leaves keeps full throughput.
    always_comb begin
        buf_valid = (state_q == ST_FULL);
        for (int k = 0; k < NUM_CH; k++) begin
            out_valid[k] = buf_valid && (sel_q == SEL_W'(k));
        end
        drain    = buf_valid & bus.out_ready[sel_q];
        eligible = (mode == MODE_DIR) ? chan_mask[bus.in_dest] : rr_any;
        // rst_n gate keeps the producer stalled while reset is held.
        in_ready = rst_n & enable & eligible & (~buf_valid | drain);
        accept   = bus.in_valid & in_ready;
        target   = (mode == MODE_DIR) ? bus.in_dest : rr_sel;
    end

    // Buffer FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath next state. Select is latched on accept, so later mask/mode
    // changes never reroute a held word.
    always_comb begin
        data_d   = data_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        if (accept) begin
            data_d = bus.in_data;
            sel_d  = target;
            if (mode == MODE_RR) begin
                rr_ptr_d = ptr_after(rr_sel);
            end
        end
        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y0        = out_valid[0] ? data_q : '0;
    assign bus.y1        = out_valid[1] ? data_q : '0;
    assign bus.y2        = out_valid[2] ? data_q : '0;
    assign bus.y3        = out_valid[3] ? data_q : '0;
    assign busy          = buf_valid;
    assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl. A second instance with a 4-bit
// counter shares the same stimulus to exercise counter wrap.
module tb_demux_dispatch_ctrl;

    localparam int unsigned N       = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_W_S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic mode = 1'b0;
    logic [3:0] chan_mask = 4'h0;
    logic busy, busy_s;
    logic [CNT_W-1:0]   xfer_cnt;
    logic [CNT_W_S-1:0] xfer_cnt_s;

    demux_dispatch_ctrl_if #(.N(N)) bus ();
    demux_dispatch_ctrl_if #(.N(N)) bus_s ();

    always #5 clk = ~clk;

    demux_dispatch_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .chan_mask (chan_mask),
        .bus       (bus),
        .busy      (busy),
        .xfer_cnt  (xfer_cnt)
    );

    demux_dispatch_ctrl #(.N(N), .CNT_W(CNT_W_S)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .chan_mask (chan_mask),
        .bus       (bus_s),
        .busy      (busy_s),
        .xfer_cnt  (xfer_cnt_s)
    );

    assign bus_s.in_data   = bus.in_data;
    assign bus_s.in_dest   = bus.in_dest;
    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.out_ready = bus.out_ready;

    typedef struct {
        int           ch;
        logic [N-1:0] data;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    model_cnt = 0;
    int    rr_ptr = 0;
    bit    mon_en = 1'b0;

    logic [3:0]   ev;
    logic [N-1:0] ey [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference target selection: first masked-in channel starting at rr_ptr.
    function automatic int rr_pick(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[(rr_ptr + i) % 4]) return (rr_ptr + i) % 4;
        end
        return -1;
    endfunction

    // Monitor: whatever word is outstanding must be on its channel only; pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                ev = 4'h0;
                for (int k = 0; k < 4; k++) ey[k] = '0;
                if (exp_q.size() > 0) begin
                    ev[exp_q[0].ch] = 1'b1;
                    ey[exp_q[0].ch] = exp_q[0].data;
                end
                check("out_valid", bus.out_valid, ev);
                check("out_valid_s", bus_s.out_valid, ev);
                check("y0", bus.y0, ey[0]);
                check("y1", bus.y1, ey[1]);
                check("y2", bus.y2, ey[2]);
                check("y3", bus.y3, ey[3]);
                check("y0_s", bus_s.y0, ey[0]);
                check("y1_s", bus_s.y1, ey[1]);
                check("y2_s", bus_s.y2, ey[2]);
                check("y3_s", bus_s.y3, ey[3]);
                check("busy", busy, exp_q.size() > 0);
                check("busy_s", busy_s, exp_q.size() > 0);
                check("xfer_cnt", xfer_cnt, model_cnt % 65536);
                check("xfer_cnt_s", xfer_cnt_s, model_cnt % 16);
                if (exp_q.size() > 0 && bus.out_ready[exp_q[0].ch]) begin
                    void'(exp_q.pop_front());
                    model_cnt++;
                end
            end
        end
    end

    // One stimulus cycle. The buffer has room when no word remains outstanding
    // after this cycle's departure (the monitor has already popped it).
    task automatic cycle(input logic en, input logic md, input logic [3:0] mask,
                         input logic vld, input logic [N-1:0] d, input logic [1:0] dest,
                         input logic [3:0] ordy);
        logic elig, exp_rdy;
        int   tgt;
        @(negedge clk);
        enable        = en;
        mode          = md;
        chan_mask     = mask;
        bus.in_valid  = vld;
        bus.in_data   = d;
        bus.in_dest   = dest;
        bus.out_ready = ordy;
        #2;
        elig    = md ? mask[dest] : (mask != 4'h0);
        exp_rdy = en && elig && (exp_q.size() == 0);
        check("in_ready", bus.in_ready, exp_rdy);
        check("in_ready_s", bus_s.in_ready, exp_rdy);
        if (vld && exp_rdy) begin
            tgt = md ? int'(dest) : rr_pick(mask);
            if (!md) rr_ptr = (tgt + 1) % 4;
            exp_q.push_back('{ch: tgt, data: d});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'hF, 1'b0, '0, 2'd0, 4'hF);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dest   = '0;
        bus.out_ready = 4'h0;
        enable        = 1'b1;
        chan_mask     = 4'hF;
        #1;
        check("rst_out_valid", bus.out_valid, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_xfer_cnt", xfer_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Round-robin at full rate.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 4'hF, 1'b1, N'(i), 2'd0, 4'hF);
        idle(2);
        check("rr_full_cnt", xfer_cnt, 8);

        // Round-robin skipping masked channels: 1, 3, 1, then 3 again.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'b1010, 1'b1, N'(4'hB + i), 2'd0, 4'hF);
        idle(2);

        // Directed with a stalled sink; other channels' readies must be ignored.
        cycle(1'b1, 1'b1, 4'hF, 1'b1, 4'h5, 2'd2, 4'b0000);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 4'hF, 1'b1, 4'h7, 2'd2, 4'b1011);
        cycle(1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 2'd2, 4'b0100);
        idle(1);

        // Mask change while full: word stays on ch3; next RR word goes elsewhere.
        cycle(1'b1, 1'b1, 4'hF, 1'b1, 4'h9, 2'd3, 4'b0000);
        cycle(1'b1, 1'b0, 4'b0111, 1'b0, 4'h0, 2'd0, 4'b0000);
        cycle(1'b1, 1'b0, 4'b0111, 1'b0, 4'h0, 2'd0, 4'b0000);
        cycle(1'b1, 1'b0, 4'b0111, 1'b1, 4'hC, 2'd0, 4'b1000);
        idle(2);

        // Blocked cases.
        cycle(1'b1, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0, 4'hF);
        cycle(1'b1, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd0, 4'hF);
        cycle(1'b1, 1'b1, 4'b1101, 1'b1, 4'h3, 2'd1, 4'hF);
        cycle(1'b1, 1'b1, 4'b1101, 1'b1, 4'h4, 2'd1, 4'hF);
        cycle(1'b1, 1'b0, 4'hF, 1'b1, 4'h6, 2'd0, 4'h0);
        cycle(1'b0, 1'b0, 4'hF, 1'b1, 4'h8, 2'd0, 4'hF);
        cycle(1'b0, 1'b0, 4'hF, 1'b1, 4'hD, 2'd0, 4'hF);
        idle(1);

        // Asynchronous reset with 4'hA held on ch2.
        cycle(1'b1, 1'b1, 4'hF, 1'b1, 4'hA, 2'd2, 4'h0);
        cycle(1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 2'd2, 4'h0);
        @(negedge clk);
        mon_en       = 1'b0;
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 4'h0);
        check("arst_y2", bus.y2, 4'h0);
        check("arst_xfer_cnt", xfer_cnt, 0);
        check("arst_busy", busy, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b0);
        exp_q.delete();
        model_cnt = 0;
        rr_ptr    = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 17 transfers wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 4'hF, 1'b1, N'(i), 2'd0, 4'hF);
        idle(2);
        check("wrap_cnt_s", xfer_cnt_s, 1);
        check("wrap_cnt", xfer_cnt, 17);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [3:0] m;
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), m,
                  ($urandom_range(0, 3) != 0), N'($urandom), 2'($urandom), 4'($urandom));
        end
        idle(4);
        check("flush_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
